// File: rtl/dafx_gain_ramp_pkg.sv
// Shared types and constants for the dafx gain ramp scheduler.
package dafx_gain_ramp_pkg;

  typedef enum logic [0:0] {
    IDLE_E   = 1'b0,
    UPDATE_E = 1'b1
  } ramp_state_t;

  localparam int OUTPUT_GAIN_CH_C    = 0;
  localparam int CHANNEL_GAIN_0_CH_C = 1;
  localparam int CHANNEL_GAIN_1_CH_C = 2;
  localparam int CHANNEL_GAIN_2_CH_C = 3;

  // Unity gain in Q format with q_bits fractional bits.
  function automatic logic [31:0] UNITY_GAIN_C(input int unsigned q_bits);
    return 32'd1 << q_bits;
  endfunction

endpackage

// File: rtl/dafx_gain_step_unit.sv
// Combinational one-channel ramp step: moves current toward target by at most step.
module dafx_gain_step_unit #(
  parameter int GAIN_WIDTH_P = 24,
  parameter int STEP_WIDTH_P = 16
) (
  input  logic [GAIN_WIDTH_P-1:0] current,
  input  logic [GAIN_WIDTH_P-1:0] target,
  input  logic [STEP_WIDTH_P-1:0] step,
  output logic [GAIN_WIDTH_P-1:0] next
);

  localparam int DW = GAIN_WIDTH_P + 1;

  logic signed [DW-1:0]       diff;
  logic        [DW-1:0]       mag;
  logic        [DW-1:0]       step_d;
  logic        [GAIN_WIDTH_P-1:0] step_g;

  assign diff   = $signed({1'b0, target}) - $signed({1'b0, current});
  assign mag    = diff[DW-1] ? DW'(-diff) : DW'(diff);
  assign step_d = DW'(step);
  assign step_g = GAIN_WIDTH_P'(step);

  // Snap when within one step, so the result never passes the target.
  always_comb begin
    if (step == '0 || mag <= step_d) next = target;
    else if (!diff[DW-1])            next = current + step_g;
    else                             next = current - step_g;
  end

endmodule

// File: rtl/dafx_gain_ramp_scheduler.sv
// Time-multiplexed gain ramp scheduler between the register slave and mixer.
// Optional overrun counter: define DAFX_GAIN_RAMP_OVERRUN_CNT_EN.
module dafx_gain_ramp_scheduler
  import dafx_gain_ramp_pkg::*;
#(
  parameter int N_CHANNELS_P = 4,
  parameter int GAIN_WIDTH_P = 24,
  parameter int Q_BITS_P     = 12,
  parameter int STEP_WIDTH_P = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sample_tick,
  input  logic                                 cr_ramp_enable,
  input  logic [STEP_WIDTH_P-1:0]              cr_ramp_step,
  input  logic [N_CHANNELS_P*GAIN_WIDTH_P-1:0] cr_target_gain,
  input  logic                                 cmd_clear_overrun,
  output logic [N_CHANNELS_P*GAIN_WIDTH_P-1:0] gain_out,
  output logic [N_CHANNELS_P-1:0]              ramp_busy,
  output logic                                 ramp_done,
  output logic                                 sr_overrun,
  output logic [15:0]                          sr_overrun_count
);

  localparam int IDX_W = (N_CHANNELS_P > 1) ? $clog2(N_CHANNELS_P) : 1;
  localparam logic [GAIN_WIDTH_P-1:0] UNITY_C = GAIN_WIDTH_P'(UNITY_GAIN_C(Q_BITS_P));
  localparam logic [IDX_W-1:0]        LAST_C  = IDX_W'(N_CHANNELS_P - 1);

  ramp_state_t                                 state;
  logic [IDX_W-1:0]                            chan_idx;
  logic [N_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0]   gain_q, tgt, gain_nxt;
  logic [N_CHANNELS_P-1:0]                     busy_nxt;
  logic [GAIN_WIDTH_P-1:0]                     step_next;
  logic                                        tick_drop;

  assign tgt       = cr_target_gain;
  assign gain_out  = gain_q;
  assign tick_drop = sample_tick && (state == UPDATE_E);

  dafx_gain_step_unit #(
    .GAIN_WIDTH_P (GAIN_WIDTH_P),
    .STEP_WIDTH_P (STEP_WIDTH_P)
  ) u_step (
    .current (gain_q[chan_idx]),
    .target  (tgt[chan_idx]),
    .step    (cr_ramp_step),
    .next    (step_next)
  );

  // An in-flight pass always completes; bypass only takes over from idle.
  always_comb begin
    gain_nxt = gain_q;
    if (state == UPDATE_E)    gain_nxt[chan_idx] = step_next;
    else if (!cr_ramp_enable) gain_nxt = tgt;
    for (int c = 0; c < N_CHANNELS_P; c++) busy_nxt[c] = (gain_nxt[c] != tgt[c]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE_E;
      chan_idx  <= '0;
      gain_q    <= {N_CHANNELS_P{UNITY_C}};
      ramp_busy <= '0;
      ramp_done <= 1'b0;
    end else begin
      gain_q    <= gain_nxt;
      ramp_busy <= busy_nxt;
      ramp_done <= (|ramp_busy) && !(|busy_nxt);
      case (state)
        IDLE_E: begin
          if (sample_tick && cr_ramp_enable) begin
            state    <= UPDATE_E;
            chan_idx <= '0;
          end
        end
        UPDATE_E: begin
          if (chan_idx == LAST_C) begin
            state    <= IDLE_E;
            chan_idx <= '0;
          end else begin
            chan_idx <= chan_idx + 1'b1;
          end
        end
        default: begin
          state    <= IDLE_E;
          chan_idx <= '0;
        end
      endcase
    end
  end

  // A dropped tick beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    sr_overrun <= 1'b0;
    else if (tick_drop)         sr_overrun <= 1'b1;
    else if (cmd_clear_overrun) sr_overrun <= 1'b0;
  end

`ifdef DAFX_GAIN_RAMP_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ovr_cnt <= '0;
    else if (tick_drop)         ovr_cnt <= (ovr_cnt == 16'hFFFF) ? ovr_cnt : ovr_cnt + 16'd1;
    else if (cmd_clear_overrun) ovr_cnt <= '0;
  end
  assign sr_overrun_count = ovr_cnt;
`else
  assign sr_overrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_dafx_gain_ramp_scheduler.sv
// Scoreboard bench for dafx_gain_ramp_scheduler (N=4, Q=12, unity=4096).
module tb_dafx_gain_ramp_scheduler;

  localparam int N  = 4;
  localparam int GW = 24;
  localparam int SW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sample_tick = 1'b0;
  logic            cr_ramp_enable = 1'b1;
  logic [SW-1:0]   cr_ramp_step = 16'd256;
  logic [N*GW-1:0] cr_target_gain;
  logic            cmd_clear_overrun = 1'b0;
  logic [N*GW-1:0] gain_out;
  logic [N-1:0]    ramp_busy;
  logic            ramp_done;
  logic            sr_overrun;
  logic [15:0]     sr_overrun_count;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [GW-1:0] exp_q[$];
  logic [GW-1:0] exp_v;

`ifdef DAFX_GAIN_RAMP_OVERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  dafx_gain_ramp_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .sample_tick       (sample_tick),
    .cr_ramp_enable    (cr_ramp_enable),
    .cr_ramp_step      (cr_ramp_step),
    .cr_target_gain    (cr_target_gain),
    .cmd_clear_overrun (cmd_clear_overrun),
    .gain_out          (gain_out),
    .ramp_busy         (ramp_busy),
    .ramp_done         (ramp_done),
    .sr_overrun        (sr_overrun),
    .sr_overrun_count  (sr_overrun_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ramp_done === 1'b1) done_cnt++;

  function automatic logic [GW-1:0] gch(input int c);
    return gain_out[c*GW +: GW];
  endfunction

  task automatic set_tgt(input int c, input logic [GW-1:0] v);
    cr_target_gain[c*GW +: GW] = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
  endtask

  task automatic pop_check(input string name, input int c);
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp_v = exp_q.pop_front();
      checks++;
      if (gch(c) !== exp_v) begin
        errors++;
        $display("FAIL %s: ch%0d got %0d expected %0d", name, c, gch(c), exp_v);
      end
    end
  endtask

  task automatic check_ovr(input string name, input logic exp_o, input int exp_cnt);
    checks++;
    if (sr_overrun !== exp_o) begin
      errors++;
      $display("FAIL %s overrun: got %b expected %b", name, sr_overrun, exp_o);
    end
    checks++;
    if (sr_overrun_count !== 16'(CNT_EN ? exp_cnt : 0)) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", name, sr_overrun_count, CNT_EN ? exp_cnt : 0);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < N; c++) set_tgt(c, 24'd4096);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    done_cnt = 0;
    cyc(4);
    for (int c = 0; c < N; c++) begin
      checks++;
      if (gch(c) !== 24'd4096) begin
        errors++;
        $display("FAIL reset_gain: ch%0d got %0d expected 4096", c, gch(c));
      end
    end
    checks++;
    if (ramp_busy !== 4'b0000 || done_cnt != 0) begin
      errors++;
      $display("FAIL reset_busy_done: busy=%b done_cnt=%0d expected 0000/0", ramp_busy, done_cnt);
    end
    check_ovr("reset", 1'b0, 0);
  endtask

  task automatic test_ramp();
    done_cnt = 0;
    set_tgt(1, 24'd8192);
    cyc(1);
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back(24'(4096 + 256 * k));
      pulse_tick();
      cyc(7);
      pop_check("ramp_step", 1);
      if (k == 15) begin
        checks++;
        if (ramp_busy[1] !== 1'b1) begin
          errors++;
          $display("FAIL ramp_busy_15: got %b expected 1", ramp_busy[1]);
        end
      end
    end
    checks++;
    if (ramp_busy !== 4'b0000) begin
      errors++;
      $display("FAIL ramp_busy_end: got %b expected 0000", ramp_busy);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL ramp_done_pulses: got %0d expected 1", done_cnt);
    end
    checks++;
    if (gch(0) !== 24'd4096 || gch(2) !== 24'd4096 || gch(3) !== 24'd4096) begin
      errors++;
      $display("FAIL ramp_others: got %0d/%0d/%0d expected 4096", gch(0), gch(2), gch(3));
    end
  endtask

  task automatic test_snap();
    set_tgt(0, 24'd4000);
    exp_q.push_back(24'd4000);
    pulse_tick();
    cyc(6);
    pop_check("snap", 0);
  endtask

  task automatic test_overrun();
    set_tgt(3, 24'd5000);
    exp_q.push_back(24'd4352);
    pulse_tick();
    cyc(1);
    pulse_tick();
    cyc(6);
    pop_check("overrun_single_step", 3);
    check_ovr("overrun_set", 1'b1, 1);
    // Clear coincident with a dropped tick: set must win.
    exp_q.push_back(24'd4608);
    pulse_tick();
    cyc(1);
    sample_tick = 1'b1;
    cmd_clear_overrun = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    cmd_clear_overrun = 1'b0;
    cyc(5);
    pop_check("overrun_second_pass", 3);
    check_ovr("set_wins", 1'b1, 2);
    cmd_clear_overrun = 1'b1;
    cyc(1);
    cmd_clear_overrun = 1'b0;
    check_ovr("clear", 1'b0, 0);
  endtask

  task automatic test_bypass();
    cr_ramp_enable = 1'b0;
    set_tgt(2, 24'd0);
    exp_q.push_back(24'd0);
    exp_q.push_back(24'd5000);
    cyc(1);
    pop_check("bypass_ch2", 2);
    pop_check("bypass_ch3", 3);
    set_tgt(1, 24'd1234);
    exp_q.push_back(24'd1234);
    cyc(1);
    pop_check("bypass_follow", 1);
    pulse_tick();
    pulse_tick();
    cyc(4);
    check_ovr("bypass_ticks_ignored", 1'b0, 0);
  endtask

  task automatic test_reset_mid_pass();
    set_tgt(1, 24'd0);
    cr_ramp_enable = 1'b1;
    cyc(1);
    pulse_tick();
    cyc(1);
    #2 rst = 1'b1;
    #1;
    for (int c = 0; c < N; c++) begin
      checks++;
      if (gch(c) !== 24'd4096) begin
        errors++;
        $display("FAIL rst_mid_gain: ch%0d got %0d expected 4096", c, gch(c));
      end
    end
    checks++;
    if (ramp_busy !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_busy: got %b expected 0000", ramp_busy);
    end
    cyc(1);
    rst = 1'b0;
    exp_q.push_back(24'd4096);
    exp_q.push_back(24'd4096);
    cyc(5);
    pop_check("no_resume_ch1", 1);
    pop_check("no_resume_ch2", 2);
    exp_q.push_back(24'd4000);
    exp_q.push_back(24'd4096);
    exp_q.push_back(24'd3840);
    pulse_tick();
    cyc(1);
    pop_check("fresh_pass_ch0", 0);
    pop_check("fresh_pass_ch1_pending", 1);
    cyc(1);
    pop_check("fresh_pass_ch1", 1);
  endtask

  initial begin
    cr_target_gain = '0;
    test_reset();
    test_ramp();
    test_snap();
    test_overrun();
    test_bypass();
    test_reset_mid_pass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dafx_gain_ramp_scheduler.md
Name: dafx_gain_ramp_scheduler

Overview:
Sequences the mixer gain path so that gain changes ramp smoothly instead of stepping, which avoids zipper noise.
- Inputs: target gains from the dafx register slave (output gain plus channel gains 0..2).
- Output: the gains actually applied to the mixer.
- A single shared step unit is time-multiplexed over all channels, one channel per clock, once per audio sample tick.
- Sits between the AXI register slave and the mixer datapath.

Parameters:
- N_CHANNELS_P, 4, number of gain channels (index 0 = output gain, 1..3 = channel gains 0..2).
- GAIN_WIDTH_P, 24, gain word width (unsigned fixed point).
- Q_BITS_P, 12, fractional bits; unity = 1<<Q_BITS_P.
- STEP_WIDTH_P, 16, ramp step width; must be <= GAIN_WIDTH_P.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_tick  in  1  single-cycle pulse, once per audio sample.
- cr_ramp_enable  in  1  1 = ramp toward targets; 0 = bypass.
- cr_ramp_step  in  STEP_WIDTH_P  gain increment per tick; 0 = snap to target.
- cr_target_gain  in  N_CHANNELS_P*GAIN_WIDTH_P  flattened targets; channel c at [c*GAIN_WIDTH_P +: GAIN_WIDTH_P].
- cmd_clear_overrun  in  1  single-cycle clear of sr_overrun.
- gain_out  out  N_CHANNELS_P*GAIN_WIDTH_P  applied gains, same packing as cr_target_gain.
- ramp_busy  out  N_CHANNELS_P  bit c = 1 while gain_out[c] != target[c].
- ramp_done  out  1  single-cycle pulse when all channels reach target.
- sr_overrun  out  1  sticky; a tick arrived while a pass was in progress.
- sr_overrun_count  out  16  overrun count (see Optional Feature).

Behaviour:
- Reset values: every gain_out channel = 1<<Q_BITS_P; ramp_busy = 0; ramp_done = 0; sr_overrun = 0; sr_overrun_count = 0; FSM = IDLE_E; chan_idx = 0.
- FSM states:
  - IDLE_E: on sample_tick with cr_ramp_enable=1 -> UPDATE_E, chan_idx <= 0.
  - UPDATE_E: processes channel chan_idx each cycle and increments chan_idx. At chan_idx = N_CHANNELS_P-1 -> IDLE_E.
- Step rule, per channel c in UPDATE_E:
  - diff = target[c] - gain_out[c], computed signed at GAIN_WIDTH_P+1 bits; step is zero-extended.
  - If step = 0 or |diff| <= step: gain_out[c] <= target[c].
  - Else if diff > 0: gain_out[c] + step. Else: gain_out[c] - step.
  - No wrap is possible: the result always lies between the current value and the target.
- Latency: channel c updates on clock edge c+1 after the tick edge. A full pass takes N_CHANNELS_P cycles.
- Target changes mid-pass: each channel samples its target in the cycle it is processed.
- Tick during UPDATE_E: the tick is dropped, sr_overrun <= 1, and the pass continues unchanged.
- Tick and cmd_clear_overrun in the same cycle: set wins.
- cmd_clear_overrun otherwise: sr_overrun <= 0 next cycle.
- Bypass (cr_ramp_enable = 0):
  - In IDLE_E: gain_out <= cr_target_gain every cycle (1-cycle latency) and ticks are ignored.
  - If enable is deasserted during UPDATE_E: the current pass finishes, then bypass applies.
- ramp_busy: registered, derived from the post-update gain_out vs target.
- ramp_done: one-cycle pulse on the cycle ramp_busy goes from nonzero to zero. Never pulses out of reset.
- rst asserted mid-pass: all outputs return to reset values asynchronously; no partial pass resumes.

Optional Feature:
- Macro: DAFX_GAIN_RAMP_OVERRUN_CNT_EN.
- Defined: sr_overrun_count increments, saturating at 16'hFFFF, on each dropped tick. cmd_clear_overrun zeroes it.
- Undefined: sr_overrun_count is tied to 0 and no counter flops are built.

Decomposition:
- Package dafx_gain_ramp_pkg holds:
  - ramp_state_t enum (IDLE_E, UPDATE_E).
  - UNITY_GAIN_C function of Q_BITS.
  - Channel index constants OUTPUT_GAIN_CH_C=0, CHANNEL_GAIN_0_CH_C=1, CHANNEL_GAIN_1_CH_C=2, CHANNEL_GAIN_2_CH_C=3.
- Sub-module dafx_gain_step_unit: combinational single-channel step computation (current, target, step -> next). Instantiated once and shared by the scheduler.

Test Plan (N=4, Q=12, unity=4096):
- Reset release -> all gain_out = 4096, ramp_busy = 4'b0000, no ramp_done pulse, sr_overrun = 0.
- enable=1, step=256, target ch1=8192, 16 ticks spaced 8 cycles apart -> ch1 steps 4352, 4608, ..., 8192 at tick 16. ramp_busy[1] falls after tick 16 and ramp_done pulses exactly once.
- ch0 target 4000, step=256 -> ch0 = 4000 after the first tick (snap, |diff| = 96); no undershoot.
- Second tick 2 cycles after the first -> sr_overrun = 1 and only one step is applied. With the macro, count = 1. cmd_clear_overrun -> sr_overrun = 0 and count = 0.
- enable=0, target ch2=0 -> gain_out ch2 = 0 one cycle later with no tick; ticks are ignored.
- rst pulsed on the 2nd cycle of UPDATE_E mid-ramp -> all gain_out = 4096 immediately, FSM idle. The next tick starts a fresh pass from channel 0.
